sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. It replaces the fixed-geometry FIFO_DUT as the next-generation buffer behind FIFO_interface-style benches. It adds configurable width and depth, a selectable first-word-fall-through (FWFT) read mode, runtime-programmable almost-full and almost-empty thresholds, an occupancy count, and a synchronous flush. It sits between a single-clock producer and a single-clock consumer, with per-request ack and error strobes.

Parameters:
- DATA_WIDTH, 16, width of data_in and data_out.
- DEPTH, 8, number of entries. Must be a power of 2 and ≥2.
- FWFT, 0. 0 = standard registered read; 1 = head word presented on data_out without a read request.
- AW, $clog2(DEPTH), derived pointer width. Not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- data_out  out  DATA_WIDTH  read data.
- af_thresh  in  AW+1  almost-full threshold; 0 disables the flag.
- ae_thresh  in  AW+1  almost-empty threshold.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- almostfull  out  1  (af_thresh!=0) && (count>=af_thresh).
- almostempty  out  1  count<=ae_thresh.
- wr_ack  out  1  registered strobe: previous-cycle write accepted.
- overflow  out  1  registered strobe: previous-cycle write rejected.
- underflow  out  1  registered strobe: previous-cycle read rejected.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr and count = 0.
  - data_out, wr_ack, overflow and underflow = 0.
  - full = 0, empty = 1, almostempty = 1.
  - almostfull = 0 unless 1 ≤ af_thresh ≤ 0.
  - Memory contents are not reset.
- Flags: full, empty, almostfull and almostempty are combinational from the count register and the threshold ports. Threshold changes take effect in the same cycle.
- Write acceptance: wr_acc = wr_en && (!full || rd_acc).
  - Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments and wraps modulo DEPTH.
- Read acceptance: rd_acc = rd_en && !empty. A write in the same cycle does not rescue a read on an empty FIFO.
- count update: +1 on write only; −1 on read only; unchanged on both or neither.
- Simultaneous access when full: the read is accepted, so the write is also accepted. count stays DEPTH, full stays high, and wr_ack = 1.
- Simultaneous access when empty: the write is accepted and the read is rejected (underflow = 1). count becomes 1.
- Strobes (next cycle, single-cycle pulses, 0 otherwise):
  - wr_ack = wr_acc.
  - overflow = wr_en && !wr_acc.
  - underflow = rd_en && !rd_acc.
- FWFT=0 mode:
  - On rd_acc, data_out <= mem[rd_ptr] and rd_ptr increments. data_out is valid the cycle after rd_en.
  - data_out holds its last value otherwise, including when empty.
- FWFT=1 mode:
  - data_out = mem[rd_ptr] combinationally; it is meaningful only when !empty.
  - After the first write into an empty FIFO, empty drops and data_out shows that word in the next cycle.
  - rd_acc consumes the displayed word; the next head appears the following cycle.
- Pointer wrap: the pointers are AW bits and wrap naturally. full/empty come from count, never from pointer compare.
- flush:
  - Has priority over wr_en and rd_en in the same cycle. Sets wr_ptr, rd_ptr and count to 0.
  - Generates no wr_ack, overflow or underflow for that cycle.
  - In FWFT=0, data_out holds its value.
- Reset asserted mid-burst: state clears immediately and asynchronously. Requests are ignored while rst_n = 0.

Test Plan:
- Parameters DATA_WIDTH=16, DEPTH=8, FWFT=0, af_thresh=6, ae_thresh=2. After reset, write 0x0001..0x0008 on consecutive cycles:
  - wr_ack high 8 cycles.
  - almostfull rises when count=6.
  - full=1 at count=8.
  - A 9th write gives overflow=1 and wr_ack=0; count stays 8.
- From full, read 8 times: data_out = 0x0001..0x0008 in order, one cycle after each rd_en. almostempty rises at count=2 and empty=1 at the end. A 9th read gives underflow=1 and data_out holds 0x0008.
- Fill to 8, then hold wr_en=rd_en=1 with data 0xA000+i for 16 cycles:
  - count stays 8, wr_ack=1 every cycle.
  - Reads return 0x0001..0x0008, then 0xA000.., covering two pointer wraps.
- When empty, assert wr_en=rd_en=1 with data 0x1234: underflow=1, wr_ack=1, count=1. The next read returns 0x1234.
- FWFT=1: write 0xBEEF into an empty FIFO.
  - The next cycle has empty=0 and data_out=0xBEEF with no rd_en.
  - Write 0xCAFE, then rd_en: data_out shows 0xCAFE the following cycle.
- With count=5, assert flush together with wr_en and rd_en: the next cycle has count=0, empty=1, wr_ack=0 and underflow=0. Separately, drop rst_n mid-burst at count=3: count=0 and empty=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO. Width and depth are configurable,
//            the read port is either registered or first-word-fall-through,
//            the almost-full/almost-empty thresholds are programmable at
//            runtime, occupancy is reported, and the contents can be cleared
//            with a synchronous flush.
// Ports    : clk          rising-edge clock
//            rst_n        asynchronous active-low reset
//            flush        synchronous clear of pointers and count
//            wr_en/data_in    write request and write data
//            rd_en/data_out   read request and read data
//            af_thresh    almost-full threshold (0 disables almostfull)
//            ae_thresh    almost-empty threshold
//            count        occupancy, 0..DEPTH
//            full/empty/almostfull/almostempty   status flags (from count)
//            wr_ack/overflow/underflow           one-cycle result strobes
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [AW:0]           af_thresh,
    input  logic [AW:0]           ae_thresh,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [AW:0] c_depth = DEPTH[AW:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_req;
    logic w_rd_req;
    logic w_rd_acc;
    logic w_wr_acc;

    // Flags are derived from the occupancy counter only, never from the
    // pointers, so wrap-around needs no extra pointer bit.
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // Flush suppresses both requests, which also keeps all strobes low.
    assign w_wr_req = wr_en && !flush;
    assign w_rd_req = rd_en && !flush;

    // A read only succeeds on real data; a full FIFO still takes a write when
    // a read frees the slot in the same cycle.
    assign w_rd_acc = w_rd_req && !w_empty;
    assign w_wr_acc = w_wr_req && (!w_full || w_rd_acc);

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= w_wr_req && !w_wr_acc;
            r_underflow <= w_rd_req && !w_rd_acc;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                // Pointers are AW bits wide and DEPTH is a power of two, so
                // the natural overflow of the increment is the wrap.
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_wr_acc, w_rd_acc})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; valid only while !empty.
            assign data_out = r_mem[r_rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] r_data_out;

            // Holds its value on idle cycles, rejected reads and flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (af_thresh != '0) && (r_count >= af_thresh);
    assign almostempty = (r_count <= ae_thresh);
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed self-checking bench for sync_fifo_param. One instance
//            uses the registered read port, a second uses FWFT. Expected read
//            data comes from a scoreboard queue filled as writes are driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;

    // Registered-read instance
    logic          flush, wr_en, rd_en;
    logic [DW-1:0] data_in, data_out;
    logic [AW:0]   count;
    logic          full, empty, almostfull, almostempty;
    logic          wr_ack, overflow, underflow;

    // FWFT instance
    logic          fw_flush, fw_wr_en, fw_rd_en;
    logic [DW-1:0] fw_data_in, fw_data_out;
    logic [AW:0]   fw_count;
    logic          fw_full, fw_empty, fw_almostfull, fw_almostempty;
    logic          fw_wr_ack, fw_overflow, fw_underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] fw_q[$];
    logic [DW-1:0] exp_dout;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en),
        .data_in(data_in), .rd_en(rd_en), .data_out(data_out),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count),
        .full(full), .empty(empty), .almostfull(almostfull),
        .almostempty(almostempty), .wr_ack(wr_ack), .overflow(overflow),
        .underflow(underflow)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(fw_flush), .wr_en(fw_wr_en),
        .data_in(fw_data_in), .rd_en(fw_rd_en), .data_out(fw_data_out),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(fw_count),
        .full(fw_full), .empty(fw_empty), .almostfull(fw_almostfull),
        .almostempty(fw_almostempty), .wr_ack(fw_wr_ack),
        .overflow(fw_overflow), .underflow(fw_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_std_flags(input string tag);
        int n;
        n = q.size();
        check({tag, ":count"}, 32'(count), 32'(n));
        check({tag, ":full"}, 32'(full), 32'(n == DEPTH));
        check({tag, ":empty"}, 32'(empty), 32'(n == 0));
        check({tag, ":almostfull"}, 32'(almostfull), 32'((af_thresh != 0) && (n >= int'(af_thresh))));
        check({tag, ":almostempty"}, 32'(almostempty), 32'(n <= int'(ae_thresh)));
        check({tag, ":data_out"}, 32'(data_out), 32'(exp_dout));
    endtask

    // One clock on the registered-read instance with scoreboard prediction.
    task automatic cycle(input string tag, input logic wr, input logic [DW-1:0] din,
                         input logic rd, input logic fl);
        logic racc, wacc, e_ack, e_ovf, e_udf;
        wr_en = wr; data_in = din; rd_en = rd; flush = fl;
        racc = 1'b0; wacc = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            racc = rd && (q.size() != 0);
            wacc = wr && ((q.size() < DEPTH) || racc);
            if (racc) exp_dout = q.pop_front();
            if (wacc) q.push_back(din);
        end
        e_ack = wacc;
        e_ovf = !fl && wr && !wacc;
        e_udf = !fl && rd && !racc;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        check({tag, ":wr_ack"}, 32'(wr_ack), 32'(e_ack));
        check({tag, ":overflow"}, 32'(overflow), 32'(e_ovf));
        check({tag, ":underflow"}, 32'(underflow), 32'(e_udf));
        check_std_flags(tag);
    endtask

    task automatic fw_cycle(input string tag, input logic wr, input logic [DW-1:0] din,
                            input logic rd);
        logic racc, wacc;
        fw_wr_en = wr; fw_data_in = din; fw_rd_en = rd;
        racc = rd && (fw_q.size() != 0);
        wacc = wr && ((fw_q.size() < DEPTH) || racc);
        if (racc) void'(fw_q.pop_front());
        if (wacc) fw_q.push_back(din);
        @(posedge clk); #1;
        fw_wr_en = 1'b0; fw_rd_en = 1'b0;
        check({tag, ":fw_count"}, 32'(fw_count), 32'(fw_q.size()));
        check({tag, ":fw_empty"}, 32'(fw_empty), 32'(fw_q.size() == 0));
        check({tag, ":fw_wr_ack"}, 32'(fw_wr_ack), 32'(wacc));
        if (fw_q.size() != 0) check({tag, ":fw_data_out"}, 32'(fw_data_out), 32'(fw_q[0]));
    endtask

    initial begin
        rst_n = 1'b0;
        af_thresh = 4'd6; ae_thresh = 4'd2;
        flush = 0; wr_en = 0; rd_en = 0; data_in = '0;
        fw_flush = 0; fw_wr_en = 0; fw_rd_en = 0; fw_data_in = '0;
        exp_dout = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst:wr_ack", 32'(wr_ack), 32'd0);
        check("rst:overflow", 32'(overflow), 32'd0);
        check("rst:underflow", 32'(underflow), 32'd0);
        check_std_flags("rst");

        // Fill 0x0001..0x0008, then one rejected write
        for (int i = 1; i <= DEPTH; i++) cycle($sformatf("fill%0d", i), 1'b1, DW'(i), 1'b0, 1'b0);
        cycle("overflow", 1'b1, 16'h0009, 1'b0, 1'b0);

        // Drain in order, then one rejected read (data_out holds 0x0008)
        for (int i = 1; i <= DEPTH; i++) cycle($sformatf("drain%0d", i), 1'b0, '0, 1'b1, 1'b0);
        cycle("underflow", 1'b0, '0, 1'b1, 1'b0);
        check("underflow:hold", 32'(data_out), 32'h0008);

        // Full, then simultaneous read/write for two pointer wraps
        for (int i = 1; i <= DEPTH; i++) cycle($sformatf("refill%0d", i), 1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle($sformatf("rw%0d", i), 1'b1, DW'(16'hA000 + i), 1'b1, 1'b0);
        check("rw:last_read", 32'(data_out), 32'h0000A007);
        for (int i = 0; i < DEPTH; i++) cycle($sformatf("drain_rw%0d", i), 1'b0, '0, 1'b1, 1'b0);

        // Simultaneous access on empty: read rejected, write accepted
        cycle("empty_rw", 1'b1, 16'h1234, 1'b1, 1'b0);
        cycle("read_1234", 1'b0, '0, 1'b1, 1'b0);
        check("read_1234:value", 32'(data_out), 32'h1234);

        // FWFT instance
        fw_cycle("fw_beef", 1'b1, 16'hBEEF, 1'b0);
        check("fw_beef:shown", 32'(fw_data_out), 32'hBEEF);
        fw_cycle("fw_cafe", 1'b1, 16'hCAFE, 1'b0);
        fw_cycle("fw_read", 1'b0, '0, 1'b1);
        check("fw_read:shown", 32'(fw_data_out), 32'hCAFE);

        // Flush at count 5 with both requests asserted
        for (int i = 0; i < 5; i++) cycle($sformatf("pre_flush%0d", i), 1'b1, DW'(16'h5000 + i), 1'b0, 1'b0);
        cycle("flush", 1'b1, 16'h5555, 1'b1, 1'b1);
        check("flush:count0", 32'(count), 32'd0);

        // Reset mid-burst at count 3
        for (int i = 0; i < 3; i++) cycle($sformatf("burst%0d", i), 1'b1, DW'(16'h7000 + i), 1'b0, 1'b0);
        wr_en = 1'b1; data_in = 16'h7777;
        #2 rst_n = 1'b0;
        #1;
        check("arst:count", 32'(count), 32'd0);
        check("arst:empty", 32'(empty), 32'd1);
        check("arst:data_out", 32'(data_out), 32'd0);
        @(posedge clk); #1;
        check("arst:ignored", 32'(count), 32'd0);
        check("arst:no_ack", 32'(wr_ack), 32'd0);
        wr_en = 1'b0;
        rst_n = 1'b1;
        q.delete();
        exp_dout = '0;
        cycle("post_rst", 1'b1, 16'h4321, 1'b0, 1'b0);
        cycle("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);
        check("post_rst_rd:value", 32'(data_out), 32'h4321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
